// File: rtl/instr_encoder.sv
// Encodes a decoded control bundle plus pre-packed operands into a 32-bit instruction word
// and streams it out with a write address through a one-entry valid/ready output register.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic [1:0]        alu_src,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              data_read_en,
    input  logic              data_write_en,
    input  logic              mem_to_reg,
    input  logic              reg_write_en,
    input  logic [24:0]       operands,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [7:0]        err_count
);

    localparam int ROWS = 15;

    // Key layout: {alu_src, alu_op, mem_to_reg, reg_write_en, data_read_en, data_write_en, beq, bne, jump}
    localparam logic [12:0] ROW_KEY [ROWS] = '{
        {2'b00, 4'b0000, 7'b0100000},
        {2'b00, 4'b0001, 7'b0100000},
        {2'b00, 4'b0010, 7'b0100000},
        {2'b00, 4'b0011, 7'b0100000},
        {2'b00, 4'b0100, 7'b0100000},
        {2'b00, 4'b0101, 7'b0100000},
        {2'b00, 4'b0110, 7'b0100000},
        {2'b00, 4'b0111, 7'b0100000},
        {2'b01, 4'b0000, 7'b1110000},
        {2'b01, 4'b0000, 7'b0001000},
        {2'b00, 4'b0001, 7'b0000100},
        {2'b00, 4'b0001, 7'b0000010},
        {2'b00, 4'b0000, 7'b0000001},
        {2'b10, 4'b1000, 7'b0100000},
        {2'b10, 4'b1001, 7'b0100000}
    };

    localparam logic [6:0] ROW_OP [ROWS] = '{
        7'b0001011, 7'b0001111, 7'b0010011, 7'b0010111,
        7'b0011011, 7'b0011111, 7'b0100011, 7'b0100111,
        7'b0000011, 7'b0000111, 7'b0101111, 7'b0110011,
        7'b0110111, 7'b0111011, 7'b0111111
    };

    logic [12:0]       key;
    logic [ROWS-1:0]   row_hit;
    logic [6:0]        opcode;
    logic              legal;
    logic              accept;
    logic              stall;
    logic [ADDR_W-1:0] word_addr;

    logic              out_valid_reg;
    logic [31:0]       out_instr_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              err_illegal_reg;
    logic [7:0]        err_count_reg;

    assign key = {alu_src, alu_op, mem_to_reg, reg_write_en, data_read_en,
                  data_write_en, beq, bne, jump};

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign row_hit[gi] = (key == ROW_KEY[gi]);
        end
    endgenerate

    // Rows are mutually exclusive, so OR-ing the hit rows yields the single matching opcode.
    always_comb begin
        opcode = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_hit[i]) begin
                opcode = opcode | ROW_OP[i];
            end
        end
    end

    assign legal     = |row_hit;
    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    assign stall     = in_valid && !in_ready;
    assign word_addr = addr_load ? addr_in : addr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg   <= 1'b0;
            out_instr_reg   <= '0;
            out_addr_reg    <= '0;
            addr_reg        <= '0;
            err_illegal_reg <= 1'b0;
            err_count_reg   <= '0;
        end else begin
            err_illegal_reg <= accept && !legal;
            if (accept && !legal && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
            if (accept && legal) begin
                out_valid_reg <= 1'b1;
                out_instr_reg <= {operands, opcode};
                out_addr_reg  <= word_addr;
                addr_reg      <= word_addr + ADDR_W'(1);
            end else begin
                if (out_ready) begin
                    out_valid_reg <= 1'b0;
                end
                // A stalled bundle must leave all state untouched, including the address.
                if (addr_load && !stall) begin
                    addr_reg <= addr_in;
                end
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_instr   = out_instr_reg;
    assign out_addr    = out_addr_reg;
    assign err_illegal = err_illegal_reg;
    assign err_count   = err_count_reg;

endmodule
